// File: rtl/tcb_full_arb.sv
// Round-robin arbiter that merges MPN manager ports onto one subordinate
// port. A request with the lock bit set keeps the grant on its manager
// until that manager completes a request with the lock bit clear.
// Responses return DLY cycles after each transfer and are routed back to
// the manager that issued the request.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   man_vld/man_rdy   per-manager handshake
//   man_req           per-manager request, manager i at [i*RQW +: RQW]
//   man_rsp           per-manager response, manager i at [i*RSW +: RSW]
//   sub_vld/sub_rdy   subordinate handshake
//   sub_req/sub_rsp   subordinate request and response
module tcb_full_arb #(
  parameter int unsigned MPN = 2,
  parameter int unsigned RQW = 72,
  parameter int unsigned RSW = 33,
  parameter int unsigned DLY = 1,
  parameter int unsigned LCK = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MPN-1:0]     man_vld,
  output logic [MPN-1:0]     man_rdy,
  input  logic [MPN*RQW-1:0] man_req,
  output logic [MPN*RSW-1:0] man_rsp,
  output logic               sub_vld,
  input  logic               sub_rdy,
  output logic [RQW-1:0]     sub_req,
  input  logic [RSW-1:0]     sub_rsp
);

  localparam int unsigned IW = (MPN > 1) ? $clog2(MPN) : 1;

  typedef enum logic {OPEN = 1'b0, LOCK = 1'b1} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] lix;
  logic [IW-1:0] hix;
  logic          stl;
  logic [IW-1:0] gnt;
  logic [IW:0]   sum;
  logic          found;
  logic          trn;
  logic          req_lck;
  logic          rsp_trn;
  logic [IW-1:0] rsp_idx;

  // Increment an index modulo MPN.
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(MPN - 1)) ? '0 : i + IW'(1);
  endfunction

  // Grant selection: locked index, held stalled index, or rotating search.
  always_comb begin
    gnt   = ptr;
    sum   = '0;
    found = 1'b0;
    if (state == LOCK) begin
      gnt = lix;
    end else if (stl) begin
      gnt = hix;
    end else begin
      for (int k = 0; k < int'(MPN); k++) begin
        sum = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(MPN)) sum = sum - (IW+1)'(MPN);
        if (!found && man_vld[sum[IW-1:0]]) begin
          gnt   = sum[IW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // Zero-latency request path.
  always_comb begin
    sub_vld = man_vld[gnt];
    sub_req = man_req[gnt*RQW +: RQW];
    man_rdy = sub_rdy ? (MPN'(1) << gnt) : '0;
  end

  assign trn     = sub_vld & sub_rdy;
  assign req_lck = (LCK != 0) & sub_req[RQW-1];

  // Arbitration state; a stalled grant in OPEN is remembered so that a newly
  // raised higher-priority valid cannot steal it before the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OPEN;
      ptr   <= '0;
      lix   <= '0;
      hix   <= '0;
      stl   <= 1'b0;
    end else begin
      stl <= sub_vld & ~sub_rdy & (state == OPEN);
      hix <= gnt;
      case (state)
        OPEN: begin
          if (trn) begin
            if (req_lck) begin
              state <= LOCK;
              lix   <= gnt;
            end else begin
              ptr <= nxt(gnt);
            end
          end
        end
        LOCK: begin
          if (trn && !req_lck) begin
            state <= OPEN;
            ptr   <= nxt(lix);
          end
        end
        default: state <= OPEN;
      endcase
    end
  end

  // Response route: {trn, gnt} delayed DLY cycles to match the subordinate.
  if (DLY == 0) begin : g_comb
    assign rsp_trn = trn;
    assign rsp_idx = gnt;
  end else begin : g_line
    logic [DLY-1:0] dtrn;
    logic [IW-1:0]  didx [DLY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dtrn <= '0;
        for (int k = 0; k < int'(DLY); k++) didx[k] <= '0;
      end else begin
        dtrn[0] <= trn;
        didx[0] <= gnt;
        for (int k = 1; k < int'(DLY); k++) begin
          dtrn[k] <= dtrn[k-1];
          didx[k] <= didx[k-1];
        end
      end
    end

    assign rsp_trn = dtrn[DLY-1];
    assign rsp_idx = didx[DLY-1];
  end

  // Steer the subordinate response to the owning manager; others see zero.
  always_comb begin
    man_rsp = '0;
    if (rsp_trn) man_rsp[rsp_idx*RSW +: RSW] = sub_rsp;
  end

endmodule

// File: tb/tb_tcb_full_arb.sv
// Scoreboard bench for tcb_full_arb: two instances (DLY=1 and DLY=0) share
// the same stimulus; a reference model predicts grants and responses.
module tb_tcb_full_arb;

  localparam int MPN = 4;
  localparam int RQW = 16;
  localparam int RSW = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [MPN-1:0]     man_vld = '0;
  logic [MPN*RQW-1:0] man_req = '0;
  logic               sub_rdy = 1'b0;
  logic [RSW-1:0]     sub_rsp = '0;

  logic [MPN-1:0]     man_rdy1, man_rdy0;
  logic [MPN*RSW-1:0] man_rsp1, man_rsp0;
  logic               sub_vld1, sub_vld0;
  logic [RQW-1:0]     sub_req1, sub_req0;

  tcb_full_arb #(.MPN(MPN), .RQW(RQW), .RSW(RSW), .DLY(1), .LCK(1)) u_d1 (
    .clk(clk), .rst(rst), .man_vld(man_vld), .man_rdy(man_rdy1),
    .man_req(man_req), .man_rsp(man_rsp1), .sub_vld(sub_vld1),
    .sub_rdy(sub_rdy), .sub_req(sub_req1), .sub_rsp(sub_rsp));

  tcb_full_arb #(.MPN(MPN), .RQW(RQW), .RSW(RSW), .DLY(0), .LCK(1)) u_d0 (
    .clk(clk), .rst(rst), .man_vld(man_vld), .man_rdy(man_rdy0),
    .man_req(man_req), .man_rsp(man_rsp0), .sub_vld(sub_vld0),
    .sub_rdy(sub_rdy), .sub_req(sub_req0), .sub_rsp(sub_rsp));

  always #5 clk = ~clk;

  typedef struct {
    bit             vld;
    logic [MPN-1:0] rdy;
    logic [RQW-1:0] req;
  } exp_t;

  typedef struct {
    int due;
    int idx;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t r1_q[$];
  rsp_t r0_q[$];
  int   obs[$];

  int cyc = 0;
  int pass = 0;
  int total = 0;

  // Reference model: ptr, locked manager (-1 = open), held stalled manager.
  int m_ptr = 0;
  int m_lock = -1;
  int m_hold = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
  endtask

  // One clock of stimulus; the model predicts this cycle's outputs.
  task automatic step(input bit rs, input logic [3:0] v, input logic [3:0] l, input bit r);
    int  g;
    bit  vld, open;
    logic [RQW-1:0] rq;
    @(posedge clk);
    #1;
    if (!rs) v = '0;
    rst     = rs;
    man_vld = v;
    for (int i = 0; i < MPN; i++) begin
      rq = RQW'($urandom);
      rq[RQW-1] = l[i];
      man_req[i*RQW +: RQW] = rq;
    end
    sub_rdy = r;
    sub_rsp = RSW'($urandom) | RSW'(1);
    if (!rs) begin
      m_ptr = 0; m_lock = -1; m_hold = -1;
      r1_q.delete();
      r0_q.delete();
    end
    if (m_lock >= 0) g = m_lock;
    else if (m_hold >= 0) g = m_hold;
    else begin
      g = m_ptr;
      for (int k = MPN - 1; k >= 0; k--)
        if (v[(m_ptr + k) % MPN]) g = (m_ptr + k) % MPN;
    end
    vld = v[g];
    exp_q.push_back('{vld: vld, rdy: r ? MPN'(1 << g) : '0, req: man_req[g*RQW +: RQW]});
    if (rs) begin
      open = (m_lock < 0);
      if (vld && r) begin
        r0_q.push_back('{due: cyc, idx: g});
        r1_q.push_back('{due: cyc + 1, idx: g});
        if (open && l[g]) m_lock = g;
        else if (open) m_ptr = (g + 1) % MPN;
        else if (!l[g]) begin
          m_ptr  = (m_lock + 1) % MPN;
          m_lock = -1;
        end
      end
      m_hold = (vld && !r && open) ? g : -1;
    end
  endtask

  // Compare the grant sequence seen on the DLY=1 instance with a constant list.
  task automatic check_seq(input string nm, input int n, input int s [8]);
    @(negedge clk);
    #1;
    chk({nm, "_len"}, 64'(obs.size()), 64'(n));
    for (int i = 0; i < n && i < obs.size(); i++)
      chk(nm, 64'(obs[i]), 64'(s[i]));
    obs.delete();
  endtask

  // Monitor: pop the expected request-side view and any due responses.
  exp_t           e;
  rsp_t           rs_e;
  logic [MPN*RSW-1:0] want;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sub_vld_d1", 64'(sub_vld1), 64'(e.vld));
      chk("man_rdy_d1", 64'(man_rdy1), 64'(e.rdy));
      chk("sub_vld_d0", 64'(sub_vld0), 64'(e.vld));
      chk("man_rdy_d0", 64'(man_rdy0), 64'(e.rdy));
      if (e.vld) begin
        chk("sub_req_d1", 64'(sub_req1), 64'(e.req));
        chk("sub_req_d0", 64'(sub_req0), 64'(e.req));
      end
      if (sub_vld1 && sub_rdy)
        for (int i = 0; i < MPN; i++) if (man_rdy1[i]) obs.push_back(i);

      want = '0;
      if (r1_q.size() != 0 && r1_q[0].due == cyc) begin
        rs_e = r1_q.pop_front();
        want[rs_e.idx*RSW +: RSW] = sub_rsp;
      end
      chk("man_rsp_d1", 64'(man_rsp1), 64'(want));

      want = '0;
      if (r0_q.size() != 0 && r0_q[0].due == cyc) begin
        rs_e = r0_q.pop_front();
        want[rs_e.idx*RSW +: RSW] = sub_rsp;
      end
      chk("man_rsp_d0", 64'(man_rsp0), 64'(want));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rs;
    // Reset.
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    obs.delete();

    // All managers valid, always ready: plain rotation.
    for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 4'h0, 1'b1);
    check_seq("rotate", 5, '{0, 1, 2, 3, 0, 0, 0, 0});

    // Locked burst from manager 2 while the others stay valid.
    step(1'b1, 4'b0010, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'b0100, 1'b1);
    step(1'b1, 4'hF, 4'b0100, 1'b1);
    step(1'b1, 4'hF, 4'b0000, 1'b1);
    step(1'b1, 4'hF, 4'b0000, 1'b1);
    check_seq("lock", 5, '{1, 2, 2, 2, 3, 0, 0, 0});

    // Stalled grant on manager 1 survives manager 0 raising valid.
    step(1'b1, 4'b0010, 4'h0, 1'b0);
    step(1'b1, 4'b0011, 4'h0, 1'b0);
    step(1'b1, 4'b0011, 4'h0, 1'b0);
    step(1'b1, 4'b0011, 4'h0, 1'b1);
    step(1'b1, 4'b0011, 4'h0, 1'b1);
    check_seq("stall", 2, '{1, 0, 0, 0, 0, 0, 0, 0});

    // Pointer wrap from manager 3 back to 0.
    step(1'b1, 4'b0100, 4'h0, 1'b1);
    step(1'b1, 4'b1000, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'h0, 1'b1);
    check_seq("wrap", 3, '{2, 3, 0, 0, 0, 0, 0, 0});

    // Reset while locked with a response in flight.
    step(1'b1, 4'b0010, 4'b0010, 1'b1);
    step(1'b1, 4'b0010, 4'b0010, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'h0, 1'b1);
    check_seq("rst_lock", 3, '{1, 1, 0, 0, 0, 0, 0, 0});

    // Randomized traffic with occasional locks, stalls and resets.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 99) != 0);
      step(rs, 4'($urandom), 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Drain and confirm nothing predicted was left unseen.
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_d1", 64'(r1_q.size()), 64'd0);
    chk("drain_d0", 64'(r0_q.size()), 64'd0);
    chk("drain_exp", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
